// File: rtl/timed_rr_arbiter_pkg.sv
// Shared arbitration types: client selection encoding, arbiter states and
// small helpers for cyclic pointer advance and one-hot decoding.
package arb_pkg;

  typedef enum logic [1:0] {
    SEL_A = 2'd0,
    SEL_B = 2'd1,
    SEL_C = 2'd2,
    SEL_X = 2'd3
  } selection;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } arb_state;

  // Cyclic successor A->B->C->A; X also maps to A so a bad pointer self-heals.
  function automatic selection next_sel(input selection s);
    case (s)
      SEL_A:   return SEL_B;
      SEL_B:   return SEL_C;
      default: return SEL_A;
    endcase
  endfunction

  function automatic logic [2:0] sel_onehot(input selection s);
    case (s)
      SEL_A:   return 3'b001;
      SEL_B:   return 3'b010;
      SEL_C:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/timed_rr_arbiter_if.sv
// Client-side request/acknowledge bundle of the three-way arbiter.
interface timed_rr_arbiter_if;
  import arb_pkg::*;

  logic [2:0] req;
  logic       clr_err;
  logic [2:0] ack;
  selection   sel;
  logic       busy;
  logic [2:0] timeout_err;

  modport master (
    output req, clr_err,
    input  ack, sel, busy, timeout_err
  );

  modport slave (
    input  req, clr_err,
    output ack, sel, busy, timeout_err
  );

endinterface

// File: rtl/timed_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr.
module rr_pick
  import arb_pkg::*;
(
  input  logic [2:0] req,
  input  selection   rr_ptr,
  output selection   pick,
  output logic       any
);

  selection cand;
  logic     found;

  always_comb begin
    pick  = SEL_X;
    found = 1'b0;
    cand  = rr_ptr;
    for (int i = 0; i < 3; i++) begin
      if (!found && ((req & sel_onehot(cand)) != 3'b000)) begin
        pick  = cand;
        found = 1'b1;
      end
      cand = next_sel(cand);
    end
  end

  assign any = |req;

endmodule

// File: rtl/timed_rr_arbiter.sv
// Three-client round-robin arbiter with four-phase req/ack handshake and a
// bounded hold time; overlong owners are revoked and flagged in timeout_err.
module timed_rr_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input logic               clk,
  input logic               rst,
  timed_rr_arbiter_if.slave bus
);

  localparam int            CW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);

  arb_state      state_q, state_d;
  selection      owner_q, owner_d;
  selection      rr_ptr_q, rr_ptr_d;
  selection      pick;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    ack_q, ack_d;
  logic [2:0]    err_q, err_d;
  logic [2:0]    owner_oh;
  logic          any_req;
  logic          owner_req;
  logic          timed_out;

  rr_pick u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .pick   (pick),
    .any    (any_req)
  );

  assign owner_oh  = sel_onehot(owner_q);
  assign owner_req = |(bus.req & owner_oh);
  assign timed_out = (MAX_HOLD != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    ack_d    = ack_q;
    // A revocation on the same edge as clr_err ORs back in below, so set wins.
    err_d    = bus.clr_err ? 3'b000 : err_q;
    case (state_q)
      IDLE: begin
        ack_d = 3'b000;
        if (any_req) begin
          owner_d = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (owner_req) begin
          ack_d   = owner_oh;
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          rr_ptr_d = next_sel(owner_q);
          owner_d  = SEL_X;
          state_d  = IDLE;
        end
      end
      HOLD: begin
        if (!owner_req) begin
          ack_d    = 3'b000;
          rr_ptr_d = next_sel(owner_q);
          owner_d  = SEL_X;
          state_d  = IDLE;
        end else if (timed_out) begin
          ack_d   = 3'b000;
          err_d   = err_d | owner_oh;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RELEASE: begin
        // Hold off until the revoked client lets go, so a stale req cannot re-win.
        ack_d = 3'b000;
        if (!owner_req) begin
          rr_ptr_d = next_sel(owner_q);
          owner_d  = SEL_X;
          state_d  = IDLE;
        end
      end
      default: begin
        ack_d   = 3'b000;
        owner_d = SEL_X;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= SEL_X;
      rr_ptr_q <= SEL_A;
      cnt_q    <= '0;
      ack_q    <= 3'b000;
      err_q    <= 3'b000;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.timeout_err = err_q;
  assign bus.sel         = (state_q == IDLE) ? SEL_X : owner_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_timed_rr_arbiter.sv
// Scoreboard bench for timed_rr_arbiter: directed stimulus queues cycle-tagged
// expectations and grant order; a negedge monitor pops and compares them.
module tb_timed_rr_arbiter;
  import arb_pkg::*;

  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  timed_rr_arbiter_if bus ();

  timed_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         cyc;
    string      name;
    logic [2:0] ack;
    logic [1:0] sel;
    logic       busy;
    logic [2:0] err;
  } exp_t;

  exp_t       sb_q[$];
  int         order_q[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [2:0] prev_ack = 3'b000;
  exp_t       mon_x;
  int         mon_o;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] oh(input int c);
    logic [2:0] one;
    one = 3'b001;
    return one << c;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int d, input string name, input logic [2:0] a,
                           input logic [1:0] s, input logic b, input logic [2:0] e);
    exp_t x;
    x.cyc  = cyc + d;
    x.name = name;
    x.ack  = a;
    x.sel  = s;
    x.busy = b;
    x.err  = e;
    sb_q.push_back(x);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  // Monitor: cycle-tagged observations, grant order on each ack rise, one-hot ack.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_x = sb_q.pop_front();
      n_checks++;
      if (mon_x.cyc != cyc || bus.ack !== mon_x.ack || 2'(bus.sel) !== mon_x.sel ||
          bus.busy !== mon_x.busy || bus.timeout_err !== mon_x.err) begin
        n_fail++;
        $display("FAIL %s cyc=%0d (due %0d): got ack=%b sel=%0d busy=%b err=%b, want ack=%b sel=%0d busy=%b err=%b",
                 mon_x.name, cyc, mon_x.cyc, bus.ack, bus.sel, bus.busy, bus.timeout_err,
                 mon_x.ack, mon_x.sel, mon_x.busy, mon_x.err);
      end
    end
    if (bus.ack != 3'b000 && prev_ack == 3'b000) begin
      n_checks++;
      if (order_q.size() == 0) begin
        n_fail++;
        $display("FAIL grant_order cyc=%0d: got ack=%b, want no grant", cyc, bus.ack);
      end else begin
        mon_o = order_q.pop_front();
        if (bus.ack !== oh(mon_o)) begin
          n_fail++;
          $display("FAIL grant_order cyc=%0d: got ack=%b, want ack=%b", cyc, bus.ack, oh(mon_o));
        end else begin
          $display("grant cyc=%0d client=%0d ack=%b", cyc, mon_o, bus.ack);
        end
      end
    end
    n_checks++;
    if (!$onehot0(bus.ack)) begin
      n_fail++;
      $display("FAIL ack_onehot cyc=%0d: got ack=%b, want one-hot or zero", cyc, bus.ack);
    end
    prev_ack <= bus.ack;
  end

  initial begin
    bus.req     = 3'b000;
    bus.clr_err = 1'b0;
    step(2);
    rst = 1'b0;
    expect_at(0, "reset", 3'b000, 2'd3, 1'b0, 3'b000);

    // Single client A, then A+B request proves rr_ptr moved to B.
    bus.req = 3'b001;
    expect_at(1, "a_sel",  3'b000, 2'd0, 1'b1, 3'b000);
    expect_at(2, "a_ack",  3'b001, 2'd0, 1'b1, 3'b000);
    expect_at(3, "a_hold", 3'b001, 2'd0, 1'b1, 3'b000);
    order_q.push_back(0);
    step(3);
    bus.req = 3'b000;
    expect_at(1, "a_rel", 3'b000, 2'd3, 1'b0, 3'b000);
    step(1);
    bus.req = 3'b011;
    expect_at(1, "ptr_b_sel", 3'b000, 2'd1, 1'b1, 3'b000);
    expect_at(2, "ptr_b_ack", 3'b010, 2'd1, 1'b1, 3'b000);
    order_q.push_back(1);
    step(2);
    bus.req = 3'b000;
    expect_at(1, "b_rel", 3'b000, 2'd3, 1'b0, 3'b000);
    step(1);

    // Fairness: all request, each drops one cycle after its ack.
    do_reset();
    bus.req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      expect_at(1, "fair_sel", 3'b000, 2'(k % 3), 1'b1, 3'b000);
      expect_at(2, "fair_ack", oh(k % 3), 2'(k % 3), 1'b1, 3'b000);
      expect_at(3, "fair_rel", 3'b000, 2'd3, 1'b0, 3'b000);
      order_q.push_back(k % 3);
      step(2);
      bus.req = 3'b111 & ~oh(k % 3);
      step(1);
      bus.req = 3'b111;
    end
    bus.req = 3'b000;

    // Timeout on B: ack high exactly MAX_HOLD cycles, no re-grant while req held.
    do_reset();
    bus.req = 3'b010;
    expect_at(1, "to_sel", 3'b000, 2'd1, 1'b1, 3'b000);
    for (int j = 2; j <= 5; j++) expect_at(j, "to_ack", 3'b010, 2'd1, 1'b1, 3'b000);
    expect_at(6, "to_revoke", 3'b000, 2'd1, 1'b1, 3'b010);
    expect_at(7, "to_no_regrant", 3'b000, 2'd1, 1'b1, 3'b010);
    expect_at(8, "to_no_regrant", 3'b000, 2'd1, 1'b1, 3'b010);
    order_q.push_back(1);
    step(8);
    bus.req = 3'b000;
    expect_at(1, "to_rel", 3'b000, 2'd3, 1'b0, 3'b010);
    step(1);

    // Release on the same edge the counter reaches MAX_HOLD-1: no error.
    bus.req = 3'b010;
    expect_at(1, "race_sel",  3'b000, 2'd1, 1'b1, 3'b010);
    expect_at(5, "race_last", 3'b010, 2'd1, 1'b1, 3'b010);
    expect_at(6, "race_rel",  3'b000, 2'd3, 1'b0, 3'b010);
    order_q.push_back(1);
    step(5);
    bus.req = 3'b000;
    step(1);

    // Timeout on A sets a second bit.
    bus.req = 3'b001;
    expect_at(1, "ato_sel",    3'b000, 2'd0, 1'b1, 3'b010);
    expect_at(2, "ato_ack",    3'b001, 2'd0, 1'b1, 3'b010);
    expect_at(6, "ato_revoke", 3'b000, 2'd0, 1'b1, 3'b011);
    order_q.push_back(0);
    step(6);
    bus.req = 3'b000;
    expect_at(1, "ato_rel", 3'b000, 2'd3, 1'b0, 3'b011);
    step(1);

    // clr_err coincident with B revocation: B stays set, A clears.
    bus.req = 3'b010;
    expect_at(2, "clr_ack",  3'b010, 2'd1, 1'b1, 3'b011);
    expect_at(6, "clr_race", 3'b000, 2'd1, 1'b1, 3'b010);
    order_q.push_back(1);
    step(5);
    bus.clr_err = 1'b1;
    step(1);
    bus.clr_err = 1'b0;
    bus.req     = 3'b000;
    expect_at(1, "clr_rel", 3'b000, 2'd3, 1'b0, 3'b010);
    step(1);
    bus.clr_err = 1'b1;
    expect_at(1, "clr_only", 3'b000, 2'd3, 1'b0, 3'b000);
    step(1);
    bus.clr_err = 1'b0;

    // Aborted request from C: one cycle of sel=C, no ack, pointer wraps to A.
    bus.req = 3'b100;
    expect_at(1, "abort_sel",  3'b000, 2'd2, 1'b1, 3'b000);
    expect_at(2, "abort_idle", 3'b000, 2'd3, 1'b0, 3'b000);
    step(1);
    bus.req = 3'b000;
    step(1);
    bus.req = 3'b011;
    expect_at(1, "abort_ptr_sel", 3'b000, 2'd0, 1'b1, 3'b000);
    expect_at(2, "abort_ptr_ack", 3'b001, 2'd0, 1'b1, 3'b000);
    order_q.push_back(0);
    step(2);
    bus.req = 3'b000;
    expect_at(1, "abort_ptr_rel", 3'b000, 2'd3, 1'b0, 3'b000);
    step(1);

    // Asynchronous reset while B holds the grant.
    bus.req = 3'b010;
    expect_at(2, "mid_ack", 3'b010, 2'd1, 1'b1, 3'b000);
    order_q.push_back(1);
    step(3);
    expect_at(0, "mid_rst", 3'b000, 2'd3, 1'b0, 3'b000);
    rst = 1'b1;
    step(1);
    rst     = 1'b0;
    bus.req = 3'b011;
    expect_at(1, "post_rst_sel", 3'b000, 2'd0, 1'b1, 3'b000);
    expect_at(2, "post_rst_ack", 3'b001, 2'd0, 1'b1, 3'b000);
    order_q.push_back(0);
    step(2);
    bus.req = 3'b000;
    expect_at(1, "post_rst_rel", 3'b000, 2'd3, 1'b0, 3'b000);
    step(3);

    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb_q.size());
    end
    n_checks++;
    if (order_q.size() != 0) begin
      n_fail++;
      $display("FAIL order_drain: got %0d grants missing, want 0", order_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
